// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller:
// cause indices, counter slot numbering and FSM state encoding.
package stall_ctrl_pkg;

   localparam int NUM_CAUSES  = 7;
   localparam int NUM_CNT     = NUM_CAUSES + 1;

   localparam int CAUSE_EXT    = 0;
   localparam int CAUSE_ROB    = 1;
   localparam int CAUSE_BRNCH  = 2;
   localparam int CAUSE_ALU    = 3;
   localparam int CAUSE_MULDIV = 4;
   localparam int CAUSE_LW     = 5;
   localparam int CAUSE_SW     = 6;
   localparam int IDX_TOTAL    = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_CAUSE
   } stall_st_e;

endpackage

// File: rtl/stall_ctrl_if.sv
// Stall/cause/counter-read bundle between the stall producer
// (master) and the pipeline front end / debug reader (slave).
interface stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stallReq;
   logic             robFull;
   logic             brnchFull;
   logic             aluFull;
   logic             mulDivFull;
   logic             lwFull;
   logic             swFull;
   logic             flush;
   logic             stall;
   logic [6:0]       stallCause;
   logic [63:0]      cycle_count;
   logic             clrCounters;
   logic             rdReq;
   logic [2:0]       rdIdx;
   logic             rdAck;
   logic [CNT_W-1:0] rdData;

   modport master (
      input  stallReq, robFull, brnchFull, aluFull,
      input  mulDivFull, lwFull, swFull, flush,
      input  clrCounters, rdReq, rdIdx,
      output stall, stallCause, cycle_count,
      output rdAck, rdData
   );

   modport slave (
      output stallReq, robFull, brnchFull, aluFull,
      output mulDivFull, lwFull, swFull, flush,
      output clrCounters, rdReq, rdIdx,
      input  stall, stallCause, cycle_count,
      input  rdAck, rdData
   );
endinterface

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating event counter; clear has priority over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/stall_ctrl.sv
// Registered stall generator with minimum stall width,
// free-running cycle counter and per-cause stall statistics.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   stall_ctrl_if.master bus
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] H_INIT = HW'(HOLD_CYCLES - 1);

   logic [NUM_CAUSES-1:0] cause;
   logic                  any_cause;
   stall_st_e             st, st_n;
   logic [HW-1:0]         h, h_n;
   logic                  stall_q;
   logic [6:0]            cause_q;
   logic [63:0]           cyc_q;
   logic                  ack_q;
   logic [CNT_W-1:0]      data_q;
   logic [NUM_CNT-1:0]    inc;
   logic [CNT_W-1:0]      cnt [NUM_CNT];

   always_comb begin
      cause               = '0;
      cause[CAUSE_EXT]    = bus.stallReq;
      cause[CAUSE_ROB]    = bus.robFull;
      cause[CAUSE_BRNCH]  = bus.brnchFull;
      cause[CAUSE_ALU]    = bus.aluFull;
      cause[CAUSE_MULDIV] = bus.mulDivFull;
      cause[CAUSE_LW]     = bus.lwFull;
      cause[CAUSE_SW]     = bus.swFull;
   end

   assign any_cause = |cause;
   assign stall_q   = (st != ST_IDLE);

   // HOLD: raised and still inside the minimum width (h != 0).
   // CAUSE: minimum width met, stays only while a cause persists.
   always_comb begin
      st_n = st;
      h_n  = h;
      case (st)
         ST_IDLE: begin
            if (any_cause) begin
               h_n  = H_INIT;
               st_n = (HOLD_CYCLES > 1) ? ST_HOLD : ST_CAUSE;
            end
         end
         ST_HOLD: begin
            h_n  = h - HW'(1);
            st_n = (h == HW'(1)) ? ST_CAUSE : ST_HOLD;
         end
         ST_CAUSE: begin
            if (!any_cause)
               st_n = ST_IDLE;
         end
         default: st_n = ST_IDLE;
      endcase
      if (bus.flush) begin
         st_n = ST_IDLE;
         h_n  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st      <= ST_IDLE;
         h       <= '0;
         cause_q <= '0;
         cyc_q   <= '0;
      end else begin
         st      <= st_n;
         h       <= h_n;
         cause_q <= cause;
         cyc_q   <= cyc_q + 64'd1;
      end
   end

   assign inc = {stall_q, cause};

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (reset_n),
         .inc   (inc[i]),
         .clr   (bus.clrCounters),
         .q     (cnt[i])
      );
   end

   // Read captures the pre-update value, so clear/inc this cycle is not seen.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ack_q  <= 1'b0;
         data_q <= '0;
      end else begin
         ack_q <= bus.rdReq;
         if (bus.rdReq)
            data_q <= cnt[bus.rdIdx];
      end
   end

   assign bus.stall       = stall_q;
   assign bus.stallCause  = cause_q;
   assign bus.cycle_count = cyc_q;
   assign bus.rdAck       = ack_q;
   assign bus.rdData      = data_q;

endmodule
